// File: rtl/p521_pkg.sv
// Shared constants, state encoding and digit helper for the p = 2^521-1 reducer.
package p521_pkg;

    localparam int SIZE           = 521;
    localparam int SIZEOF_DIGITS  = 32;
    localparam int DIGITS         = 17;
    localparam int TOP_DIGIT_BITS = 9;
    localparam int WORK_BITS      = DIGITS * SIZEOF_DIGITS;
    localparam int CNT_BITS       = 5;

    localparam logic [SIZE-1:0]     P521     = {SIZE{1'b1}};
    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_FOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // True when every valid bit of the digit is set (the top digit has only 9 valid bits).
    function automatic logic digit_all_ones(input logic [SIZEOF_DIGITS-1:0] d, input logic top);
        logic res;
        if (top) begin
            res = (d[TOP_DIGIT_BITS-1:0] == {TOP_DIGIT_BITS{1'b1}});
        end else begin
            res = (d == {SIZEOF_DIGITS{1'b1}});
        end
        return res;
    endfunction

endpackage

// File: rtl/p521_reduce_digitized_if.sv
// Request/result bundle between the multiplier side (master) and the reducer (slave).
interface p521_reduce_digitized_if;
    import p521_pkg::*;

    logic                  start;
    logic [2*SIZE-1:0]     c_in;
    logic [SIZE-1:0]       r;
    logic                  done;
    logic                  busy;

    modport master (output start, c_in, input r, done, busy);
    modport slave  (input start, c_in, output r, done, busy);

endinterface

// File: rtl/p521_reduce_digitized_digit_add.sv
// One-digit adder with carry, shared by the ADD and FOLD passes.
module p521_digit_add
    import p521_pkg::*;
(
    input  logic [SIZEOF_DIGITS-1:0] a,
    input  logic [SIZEOF_DIGITS-1:0] b,
    input  logic                     cin,
    output logic [SIZEOF_DIGITS-1:0] sum,
    output logic                     cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SIZEOF_DIGITS{1'b0}}, cin};

endmodule

// File: rtl/p521_reduce_digitized.sv
// Digit-serial reduction of a 1042-bit product modulo 2^521-1.
// Optional macro FAST_FOLD_EN skips the fold pass when the first pass produced no fold bit.
module p521_reduce_digitized
    import p521_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    p521_reduce_digitized_if.slave bus
);

    state_t                    state_r;
    logic [CNT_BITS-1:0]       cnt_r;
    logic                      carry_r;
    logic                      allones_r;
    logic                      fold_r;
    logic [SIZE-1:0]           r_r;
    logic                      done_r;
    logic                      busy_r;
    logic [WORK_BITS-1:0]      sum_r;
    logic [WORK_BITS-1:0]      hi_r;

    logic                      last_s;
    logic [9:0]                idx_s;
    logic [SIZEOF_DIGITS-1:0]  add_a_s;
    logic [SIZEOF_DIGITS-1:0]  add_b_s;
    logic [SIZEOF_DIGITS-1:0]  raw_s;
    logic                      cout_s;
    logic [SIZEOF_DIGITS-1:0]  digit_s;
    logic [WORK_BITS-1:0]      sum_upd_s;
    logic                      allones_upd_s;
    logic                      fold_bit_s;

    assign last_s = (cnt_r == LAST_IDX);
    assign idx_s  = {cnt_r, 5'b00000};

    // Operand selection: hi digit during ADD, the fold bit into digit 0 during FOLD.
    always_comb begin
        add_a_s = sum_r[idx_s +: SIZEOF_DIGITS];
        add_b_s = {SIZEOF_DIGITS{1'b0}};
        if (state_r == ST_ADD) begin
            add_b_s = hi_r[idx_s +: SIZEOF_DIGITS];
        end else if (cnt_r == {CNT_BITS{1'b0}}) begin
            add_b_s = {{(SIZEOF_DIGITS-1){1'b0}}, fold_r};
        end else begin
            add_b_s = {SIZEOF_DIGITS{1'b0}};
        end
    end

    p521_digit_add u_digit_add (
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (carry_r),
        .sum  (raw_s),
        .cout (cout_s)
    );

    // Mask the top digit to its valid bits and splice the new digit into the running sum.
    always_comb begin
        if (last_s) begin
            digit_s = {{(SIZEOF_DIGITS-TOP_DIGIT_BITS){1'b0}}, raw_s[TOP_DIGIT_BITS-1:0]};
        end else begin
            digit_s = raw_s;
        end
        fold_bit_s                          = raw_s[TOP_DIGIT_BITS];
        sum_upd_s                           = sum_r;
        sum_upd_s[idx_s +: SIZEOF_DIGITS]   = digit_s;
        allones_upd_s                       = allones_r & digit_all_ones(digit_s, last_s);
    end

    // Work registers: operand capture and per-digit sum update (deliberately not reset).
    always_ff @(posedge clk) begin
        if (state_r == ST_IDLE && bus.start) begin
            sum_r <= {{(WORK_BITS-SIZE){1'b0}}, bus.c_in[SIZE-1:0]};
            hi_r  <= {{(WORK_BITS-SIZE){1'b0}}, bus.c_in[2*SIZE-1:SIZE]};
        end else if (state_r == ST_ADD || state_r == ST_FOLD) begin
            sum_r <= sum_upd_s;
        end else begin
            sum_r <= sum_r;
        end
    end

    // Control FSM with registered result, done and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_BITS{1'b0}};
            carry_r   <= 1'b0;
            allones_r <= 1'b1;
            fold_r    <= 1'b0;
            r_r       <= {SIZE{1'b0}};
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r   <= ST_ADD;
                        busy_r    <= 1'b1;
                        cnt_r     <= {CNT_BITS{1'b0}};
                        carry_r   <= 1'b0;
                        allones_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_ADD: begin
                    carry_r <= cout_s;
`ifdef FAST_FOLD_EN
                    allones_r <= allones_upd_s;
`endif
                    if (last_s) begin
                        cnt_r   <= {CNT_BITS{1'b0}};
                        carry_r <= 1'b0;
                        fold_r  <= fold_bit_s;
`ifdef FAST_FOLD_EN
                        if (!fold_bit_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            r_r     <= allones_upd_s ? {SIZE{1'b0}} : sum_upd_s[SIZE-1:0];
                        end else begin
                            state_r   <= ST_FOLD;
                            allones_r <= 1'b1;
                        end
`else
                        state_r   <= ST_FOLD;
                        allones_r <= 1'b1;
`endif
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                ST_FOLD: begin
                    carry_r   <= cout_s;
                    allones_r <= allones_upd_s;
                    if (last_s) begin
                        state_r <= ST_DONE;
                        cnt_r   <= {CNT_BITS{1'b0}};
                        carry_r <= 1'b0;
                        done_r  <= 1'b1;
                        // A folded value of exactly p is the zero residue.
                        r_r     <= allones_upd_s ? {SIZE{1'b0}} : sum_upd_s[SIZE-1:0];
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.r    = r_r;
    assign bus.done = done_r;
    assign bus.busy = busy_r;

endmodule

// File: tb/tb_p521_reduce_digitized.sv
// Directed and model-checked vectors for the 2^521-1 reducer, including reset abort and ignored starts.
module tb_p521_reduce_digitized;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    p521_reduce_digitized_if bus ();

    p521_reduce_digitized dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [520:0] obs, input logic [520:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one reduction; poke adds a start during busy and another during the done cycle.
    task automatic run_op(input string tag, input logic [1041:0] c, input logic [520:0] exp_r,
                          input bit poke);
        int           cyc;
        int           busy_cnt;
        int           exp_lat;
        logic [521:0] s;
        s = {1'b0, c[520:0]} + {1'b0, c[1041:521]};
`ifdef FAST_FOLD_EN
        exp_lat = s[521] ? 35 : 18;
`else
        exp_lat = 35;
`endif
        @(negedge clk);
        bus.start = 1'b1;
        bus.c_in  = c;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.c_in  = ~c;
        cyc       = 1;
        busy_cnt  = 0;
        while (!bus.done && cyc < 60) begin
            if (bus.busy) busy_cnt++;
            bus.start = (poke && cyc == 5);
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        if (bus.busy) busy_cnt++;
        check({tag, " latency"}, 521'(cyc), 521'(exp_lat));
        check({tag, " r"}, bus.r, exp_r);
        check({tag, " busy cycles"}, 521'(busy_cnt), 521'(exp_lat));
        bus.start = poke;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, " done low after"}, 521'(bus.done), 521'd0);
        check({tag, " busy low after"}, 521'(bus.busy), 521'd0);
        if (poke) begin
            @(posedge clk);
            #1;
            check({tag, " no extra op"}, 521'({bus.busy, bus.done}), 521'd0);
            check({tag, " r held"}, bus.r, exp_r);
        end
    endtask

    initial begin
        logic [520:0]  p_v;
        logic [1041:0] pw;
        logic [1041:0] pm1;
        logic [1041:0] c;
        logic [1041:0] m;
        logic [1055:0] w;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.c_in  = 1042'd0;
        p_v       = {521{1'b1}};
        pw        = {521'd0, p_v};
        pm1       = {521'd0, p_v - 521'd1};

        repeat (3) @(posedge clk);
        #1;
        check("reset r", bus.r, 521'd0);
        check("reset done", 521'(bus.done), 521'd0);
        check("reset busy", 521'(bus.busy), 521'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("zero", 1042'd0, 521'd0, 1'b0);
        c = 1042'd1 << 521;
        run_op("two_pow_521", c, 521'd1, 1'b1);
        run_op("p", pw, 521'd0, 1'b0);
        c = pm1 * pm1;
        run_op("pm1_squared", c, 521'd1, 1'b0);
        c = {1042{1'b1}};
        run_op("all_ones", c, 521'd0, 1'b1);
        c = 1042'd5;
        run_op("five", c, 521'd5, 1'b0);
        c = (1042'd7 << 521) | 1042'd3;
        run_op("hi7_lo3", c, 521'd10, 1'b0);

        for (int i = 0; i < 200; i++) begin
            for (int j = 0; j < 33; j++) begin
                w[j*32 +: 32] = $urandom;
            end
            c = w[1041:0];
            if (i == 0) c = {p_v, p_v};
            if (i == 1) c = {p_v, 521'd0};
            m = c % pw;
            run_op($sformatf("rand%0d", i), c, m[520:0], (i % 4) == 0);
        end

        // Abort mid-ADD after a known nonzero result is on r.
        run_op("pre_abort", 1042'd9, 521'd9, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.c_in  = 1042'd123;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort busy", 521'(bus.busy), 521'd0);
        check("abort done", 521'(bus.done), 521'd0);
        check("abort r", bus.r, 521'd0);
        repeat (40) begin
            @(posedge clk);
            #1;
            check("abort no done", 521'(bus.done), 521'd0);
        end
        c = (1042'd1 << 1000) | 1042'd77;
        m = c % pw;
        run_op("after_abort", c, m[520:0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
